// File: rtl/fc_layer_sequencer_if.sv
// Handshake and memory-port bundle between the FC layer sequencer and its
// input/weight/bias/output buffers plus the top-level controller.
interface fc_layer_sequencer_if #(
   parameter int WORD_SIZE     = 16,
   parameter int IP_LAYER_SIZE = 128,
   parameter int OP_LAYER_SIZE = 84
);
   localparam int XA_W = $clog2(IP_LAYER_SIZE);
   localparam int WA_W = $clog2(IP_LAYER_SIZE * OP_LAYER_SIZE);
   localparam int BA_W = $clog2(OP_LAYER_SIZE);

   logic                 start;
   logic                 busy;
   logic                 done;
   logic [XA_W-1:0]      x_addr;
   logic [WORD_SIZE-1:0] x_rdata;
   logic [WA_W-1:0]      w_addr;
   logic [WORD_SIZE-1:0] w_rdata;
   logic [BA_W-1:0]      b_addr;
   logic [WORD_SIZE-1:0] b_rdata;
   logic                 z_we;
   logic [BA_W-1:0]      z_addr;
   logic [WORD_SIZE-1:0] z_wdata;

   modport master (
      input  start, x_rdata, w_rdata, b_rdata,
      output busy, done, x_addr, w_addr, b_addr, z_we, z_addr, z_wdata
   );

   modport slave (
      output start, x_rdata, w_rdata, b_rdata,
      input  busy, done, x_addr, w_addr, b_addr, z_we, z_addr, z_wdata
   );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Single-MAC fully-connected layer: Z[j] = sat(sum_i X[i]*W[j][i] + B[j]),
// sequencing addresses over 1-cycle sync-read buffers.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | first operand addresses for neuron j presented
// S_MAC   | one multiply-accumulate per cycle, IP_LAYER_SIZE cycles
// S_WRITE | saturated result written to z_addr = j
// S_DONE  | one-cycle completion pulse
module fc_layer_sequencer #(
   parameter int WORD_SIZE     = 16,
   parameter int FRAC_BITS     = 8,
   parameter int IP_LAYER_SIZE = 128,
   parameter int OP_LAYER_SIZE = 84,
   parameter bit RELU_EN       = 1'b0
) (
   input logic                  clk,
   input logic                  reset,
   fc_layer_sequencer_if.master bus
);
   localparam int XA_W   = $clog2(IP_LAYER_SIZE);
   localparam int WA_W   = $clog2(IP_LAYER_SIZE * OP_LAYER_SIZE);
   localparam int BA_W   = $clog2(OP_LAYER_SIZE);
   localparam int PROD_W = 2 * WORD_SIZE;
   localparam int ACC_W  = 2 * WORD_SIZE + $clog2(IP_LAYER_SIZE) + 1;

   localparam logic [XA_W-1:0] LAST_I = XA_W'(IP_LAYER_SIZE - 1);
   localparam logic [BA_W-1:0] LAST_J = BA_W'(OP_LAYER_SIZE - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WORD_SIZE - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;

   state_t                   state, state_nxt;
   logic [XA_W-1:0]          mac_cnt;
   logic [BA_W-1:0]          j_cnt;
   logic [XA_W-1:0]          x_addr_q;
   logic [WA_W-1:0]          w_addr_q;
   logic [BA_W-1:0]          b_addr_q;
   logic signed [ACC_W-1:0]  acc;

   logic [PROD_W-1:0]        prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_sh;
   logic [WORD_SIZE-1:0]     z_sat;
   logic                     first_mac;

   // Lower half of an unsigned product of sign-extended operands equals the signed product.
   assign prod     = {{WORD_SIZE{bus.x_rdata[WORD_SIZE-1]}}, bus.x_rdata}
                   * {{WORD_SIZE{bus.w_rdata[WORD_SIZE-1]}}, bus.w_rdata};
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-WORD_SIZE-FRAC_BITS){bus.b_rdata[WORD_SIZE-1]}},
                      bus.b_rdata, {FRAC_BITS{1'b0}}};
   assign first_mac = (mac_cnt == LAST_I);
   assign acc_sh    = acc >>> FRAC_BITS;

   always_comb begin
      z_sat = acc_sh[WORD_SIZE-1:0];
      if (acc_sh > SAT_MAX)
         z_sat = {1'b0, {(WORD_SIZE-1){1'b1}}};
      else if (acc_sh < SAT_MIN)
         z_sat = {1'b1, {(WORD_SIZE-1){1'b0}}};
      if (RELU_EN && z_sat[WORD_SIZE-1])
         z_sat = '0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_MAC;
         S_MAC:   if (mac_cnt == '0) state_nxt = S_WRITE;
         S_WRITE: state_nxt = (j_cnt == LAST_J) ? S_DONE : S_FETCH;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         mac_cnt  <= '0;
         j_cnt    <= '0;
         x_addr_q <= '0;
         w_addr_q <= '0;
         b_addr_q <= '0;
         acc      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  j_cnt    <= '0;
                  x_addr_q <= '0;
                  w_addr_q <= '0;
                  b_addr_q <= '0;
               end
            end
            S_FETCH: begin
               mac_cnt  <= LAST_I;
               x_addr_q <= x_addr_q + 1'b1;
               w_addr_q <= w_addr_q + 1'b1;
            end
            S_MAC: begin
               acc <= (first_mac ? bias_ext : acc) + prod_ext;
               if (mac_cnt != '0)
                  mac_cnt <= mac_cnt - 1'b1;
               if (x_addr_q != LAST_I) begin
                  x_addr_q <= x_addr_q + 1'b1;
                  w_addr_q <= w_addr_q + 1'b1;
               end
            end
            S_WRITE: begin
               // w_addr was held at j*IP+IP-1, so +1 is the next neuron's base row.
               j_cnt <= j_cnt + 1'b1;
               if (j_cnt != LAST_J) begin
                  x_addr_q <= '0;
                  w_addr_q <= w_addr_q + 1'b1;
                  b_addr_q <= j_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.z_we    = (state == S_WRITE);
   assign bus.z_addr  = j_cnt;
   assign bus.z_wdata = (state == S_WRITE) ? z_sat : '0;
   assign bus.x_addr  = x_addr_q;
   assign bus.w_addr  = w_addr_q;
   assign bus.b_addr  = b_addr_q;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: two instances (RELU off/on) share the same
// buffer contents and are checked against an arithmetic golden model.
module tb_fc_layer_sequencer;
   localparam int WS = 16;
   localparam int FB = 8;
   localparam int IP = 128;
   localparam int OP = 84;
   localparam int NEURON_CYC = IP + 2;
   localparam int DONE_LAT   = OP * NEURON_CYC + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   fc_layer_sequencer_if #(.WORD_SIZE(WS), .IP_LAYER_SIZE(IP), .OP_LAYER_SIZE(OP)) bi0 ();
   fc_layer_sequencer_if #(.WORD_SIZE(WS), .IP_LAYER_SIZE(IP), .OP_LAYER_SIZE(OP)) bi1 ();

   fc_layer_sequencer #(.WORD_SIZE(WS), .FRAC_BITS(FB), .IP_LAYER_SIZE(IP),
                        .OP_LAYER_SIZE(OP), .RELU_EN(1'b0))
      dut0 (.clk(clk), .reset(reset), .bus(bi0));
   fc_layer_sequencer #(.WORD_SIZE(WS), .FRAC_BITS(FB), .IP_LAYER_SIZE(IP),
                        .OP_LAYER_SIZE(OP), .RELU_EN(1'b1))
      dut1 (.clk(clk), .reset(reset), .bus(bi1));

   assign bi0.start = start;
   assign bi1.start = start;

   logic [WS-1:0] xm [IP];
   logic [WS-1:0] wm [IP*OP];
   logic [WS-1:0] bm [OP];

   always @(posedge clk) begin
      bi0.x_rdata <= xm[bi0.x_addr];
      bi0.w_rdata <= wm[bi0.w_addr];
      bi0.b_rdata <= bm[bi0.b_addr];
      bi1.x_rdata <= xm[bi1.x_addr];
      bi1.w_rdata <= wm[bi1.w_addr];
      bi1.b_rdata <= bm[bi1.b_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            a0[$], a1[$], c0[$];
   logic [WS-1:0] d0[$], d1[$];
   int            done_cnt = 0;

   always @(negedge clk) begin
      if (bi0.z_we === 1'b1) begin
         a0.push_back(int'(bi0.z_addr));
         d0.push_back(bi0.z_wdata);
         c0.push_back(cyc);
      end
      if (bi1.z_we === 1'b1) begin
         a1.push_back(int'(bi1.z_addr));
         d1.push_back(bi1.z_wdata);
      end
      if (bi0.done === 1'b1) done_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Golden neuron: exact sum in 64-bit, floor by arithmetic shift, clamp, optional ReLU.
   function automatic logic [WS-1:0] model(input int j, input bit relu);
      longint s;
      logic [WS-1:0] r;
      s = longint'($signed(bm[j])) * (longint'(1) << FB);
      for (int i = 0; i < IP; i++)
         s += longint'($signed(xm[i])) * longint'($signed(wm[j*IP+i]));
      s = s >>> FB;
      if (s > 32767)       r = 16'h7FFF;
      else if (s < -32768) r = 16'h8000;
      else                 r = s[WS-1:0];
      if (relu && r[WS-1]) r = '0;
      return r;
   endfunction

   task automatic fill(input int mode);
      for (int i = 0; i < IP; i++) begin
         case (mode)
            0, 1, 2: xm[i] = 16'h0100;
            3:       xm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
            default: xm[i] = 16'($urandom);
         endcase
      end
      for (int j = 0; j < OP; j++) begin
         case (mode)
            0:       bm[j] = 16'(j * 256);
            1:       bm[j] = 16'h0000;
            2:       bm[j] = 16'hFF00;
            default: bm[j] = 16'($urandom);
         endcase
         for (int i = 0; i < IP; i++) begin
            case (mode)
               0:       wm[j*IP+i] = 16'h0002;
               1:       wm[j*IP+i] = 16'h0100;
               2:       wm[j*IP+i] = 16'hFF00;
               3:       wm[j*IP+i] = 16'($urandom_range(0, 1023)) - 16'd512;
               default: wm[j*IP+i] = 16'($urandom);
            endcase
         end
      end
   endtask

   task automatic clear_logs();
      a0.delete(); a1.delete(); c0.delete(); d0.delete(); d1.delete();
      done_cnt = 0;
   endtask

   // Full run; poke_at > 1 re-pulses start while busy at that cycle index.
   task automatic do_run(input string name, input int poke_at);
      int n;
      int t0;
      clear_logs();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      t0 = cyc;
      chk({name, ":busy_after_start"}, bi0.busy, 1);
      chk({name, ":busy_after_start_relu"}, bi1.busy, 1);
      n = 1;
      while (bi0.done !== 1'b1 && n < DONE_LAT + 200) begin
         @(negedge clk);
         n++;
         start = (n == poke_at);
      end
      start = 1'b0;
      chk({name, ":done_latency"}, n, DONE_LAT);
      chk({name, ":done_relu"}, bi1.done, 1);
      @(negedge clk);
      chk({name, ":done_width"}, bi0.done, 0);
      chk({name, ":busy_after_done"}, bi0.busy, 0);
      repeat (3) @(negedge clk);
      chk({name, ":done_count"}, done_cnt, 1);
      chk({name, ":write_count"}, a0.size(), OP);
      chk({name, ":write_count_relu"}, a1.size(), OP);
      for (int k = 0; k < OP && k < a0.size() && k < a1.size(); k++) begin
         chk($sformatf("%s:z_addr[%0d]", name, k), a0[k], k);
         chk($sformatf("%s:z_addr_relu[%0d]", name, k), a1[k], k);
         chk($sformatf("%s:z[%0d]", name, k), d0[k], model(k, 1'b0));
         chk($sformatf("%s:z_relu[%0d]", name, k), d1[k], model(k, 1'b1));
         chk($sformatf("%s:write_time[%0d]", name, k), c0[k] - t0 + 1, NEURON_CYC * (k + 1));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst:busy", bi0.busy, 0);
      chk("rst:done", bi0.done, 0);
      chk("rst:z_we", bi0.z_we, 0);
      chk("rst:x_addr", bi0.x_addr, 0);
      chk("rst:w_addr", bi0.w_addr, 0);
      chk("rst:b_addr", bi0.b_addr, 0);
      chk("rst:z_addr", bi0.z_addr, 0);
      chk("rst:z_wdata", bi0.z_wdata, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle:busy", bi0.busy, 0);

      fill(0);
      do_run("bias_ramp", 500);
      if (d0.size() == OP && d1.size() == OP) begin
         chk("bias_ramp:z0", d0[0], 16'h0100);
         chk("bias_ramp:z83", d0[OP-1], 16'h5400);
         chk("bias_ramp:z83_relu", d1[OP-1], 16'h5400);
      end else
         chk("bias_ramp:size", d0.size(), OP);

      fill(1);
      do_run("sat_pos", 0);
      if (d0.size() == OP) begin
         chk("sat_pos:z0", d0[0], 16'h7FFF);
         chk("sat_pos:z83", d0[OP-1], 16'h7FFF);
      end

      fill(2);
      do_run("sat_neg", 0);
      if (d0.size() == OP && d1.size() == OP) begin
         chk("sat_neg:z0", d0[0], 16'h8000);
         chk("sat_neg:z0_relu", d1[0], 16'h0000);
         chk("sat_neg:z83_relu", d1[OP-1], 16'h0000);
      end

      fill(3);
      begin
         int n;
         clear_logs();
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
         n = 0;
         while (a0.size() < 10 && n < 20 * NEURON_CYC) begin
            @(negedge clk);
            n++;
         end
         repeat (20) @(negedge clk);
         chk("abort:mid_mac_busy", bi0.busy, 1);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         chk("abort:busy", bi0.busy, 0);
         chk("abort:busy_relu", bi1.busy, 0);
         chk("abort:z_we", bi0.z_we, 0);
         repeat (2 * NEURON_CYC) @(negedge clk);
         chk("abort:writes", a0.size(), 10);
         chk("abort:writes_relu", a1.size(), 10);
         chk("abort:idle", bi0.busy, 0);
      end
      do_run("rand_small", 0);

      fill(4);
      do_run("rand_full", 3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
